// File: rtl/stoch_conv_pkg.sv
// Shared types and geometry helpers for the stochastic im2col / col2im stages.
package stoch_conv_pkg;

  typedef enum logic {
    ACCUM = 1'b0,
    DRAIN = 1'b1
  } col2im_state_t;

  function automatic int conv_out_dim(input int im, input int pad, input int k, input int stride);
    return (im + 2 * pad - k) / stride + 1;
  endfunction

  function automatic int ceil_div(input int a, input int b);
    return (a + b - 1) / b;
  endfunction

endpackage

// File: rtl/stoch_signed_col2im_if.sv
// Patch-in / frame-out handshake bundle for the signed col2im stage.
interface stoch_signed_col2im_if #(
  parameter int COL_WIDTH = 18,
  parameter int IM_HEIGHT = 4,
  parameter int IM_WIDTH  = 4,
  parameter int CHANNELS  = 2,
  parameter int CNT_W     = 5
);
  logic                 in_valid;
  logic                 in_ready;
  logic [COL_WIDTH-1:0] in_p;
  logic [COL_WIDTH-1:0] in_m;
  logic                 out_valid;
  logic                 out_ready;
  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] out_sum;

  modport master (
    output in_valid, in_p, in_m, out_ready,
    input  in_ready, out_valid, out_sum
  );

  modport slave (
    input  in_valid, in_p, in_m, out_ready,
    output in_ready, out_valid, out_sum
  );
endinterface

// File: rtl/stoch_signed_acc_cell.sv
// Signed up/down counter for one pixel/channel; moves at most one step per beat.
module stoch_signed_acc_cell #(
  parameter int CNT_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             en,
  input  logic             clr,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_reg;

  // p=m=1 cancels, so only a lone rail moves the count
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en && inc && !dec) begin
      cnt_reg <= cnt_reg + ONE;
    end else if (en && dec && !inc) begin
      cnt_reg <= cnt_reg - ONE;
    end
  end

  assign cnt = cnt_reg;
endmodule

// File: rtl/stoch_signed_col2im.sv
// Folds signed column-format bitstream patches back onto the image, accumulating overlaps.
module stoch_signed_col2im
  import stoch_conv_pkg::*;
#(
  parameter int IM_HEIGHT = 4,
  parameter int IM_WIDTH  = 4,
  parameter int CHANNELS  = 2,
  parameter int KERNEL_H  = 3,
  parameter int KERNEL_W  = 3,
  parameter int PAD_H     = 1,
  parameter int PAD_W     = 1,
  parameter int STRIDE_H  = 1,
  parameter int STRIDE_W  = 1
) (
  input logic CLK,
  input logic nRST,
  stoch_signed_col2im_if.slave bus
);
  localparam int OUT_W     = conv_out_dim(IM_WIDTH, PAD_W, KERNEL_W, STRIDE_W);
  localparam int OUT_H     = conv_out_dim(IM_HEIGHT, PAD_H, KERNEL_H, STRIDE_H);
  localparam int COL_WIDTH = KERNEL_H * KERNEL_W * CHANNELS;
  localparam int MAX_OVL   = ceil_div(KERNEL_H, STRIDE_H) * ceil_div(KERNEL_W, STRIDE_W);
  localparam int CNT_W     = $clog2(MAX_OVL + 1) + 1;
  localparam int CW_W      = (COL_WIDTH > 1) ? $clog2(COL_WIDTH) : 1;
  localparam int OX_W      = (OUT_W > 1) ? $clog2(OUT_W) : 1;
  localparam int OY_W      = (OUT_H > 1) ? $clog2(OUT_H) : 1;
  localparam logic [OX_W-1:0] OX_LAST = OX_W'(OUT_W - 1);
  localparam logic [OY_W-1:0] OY_LAST = OY_W'(OUT_H - 1);
  localparam logic [OX_W-1:0] OX_ONE  = OX_W'(1);
  localparam logic [OY_W-1:0] OY_ONE  = OY_W'(1);

  col2im_state_t   state_reg;
  logic [OX_W-1:0] ox_reg;
  logic [OY_W-1:0] oy_reg;
  logic            in_ready_reg;
  logic            out_valid_reg;
  logic            accept;
  logic            clr;

  logic [IM_HEIGHT-1:0][IM_WIDTH-1:0][CHANNELS-1:0][CNT_W-1:0] sum_w;

  assign accept = bus.in_valid && in_ready_reg;
  assign clr    = out_valid_reg && bus.out_ready;

  // Patch origin is tracked as (oy, ox) directly so no divider is needed
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_reg     <= ACCUM;
      ox_reg        <= '0;
      oy_reg        <= '0;
      in_ready_reg  <= 1'b1;
      out_valid_reg <= 1'b0;
    end else begin
      case (state_reg)
        ACCUM: begin
          if (bus.in_valid) begin
            if (ox_reg == OX_LAST) begin
              ox_reg <= '0;
              if (oy_reg == OY_LAST) begin
                oy_reg        <= '0;
                state_reg     <= DRAIN;
                in_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
              end else begin
                oy_reg <= oy_reg + OY_ONE;
              end
            end else begin
              ox_reg <= ox_reg + OX_ONE;
            end
          end
        end
        DRAIN: begin
          if (bus.out_ready) begin
            state_reg     <= ACCUM;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
          end
        end
      endcase
    end
  end

  // Each cell inverts the scatter: find which kernel tap of the current patch lands on it
  for (genvar gi_y = 0; gi_y < IM_HEIGHT; gi_y++) begin : g_row
    for (genvar gi_x = 0; gi_x < IM_WIDTH; gi_x++) begin : g_col
      for (genvar gi_c = 0; gi_c < CHANNELS; gi_c++) begin : g_ch
        int               kr;
        int               kc;
        int               c;
        logic             hit;
        logic             inc;
        logic             dec;
        logic [CNT_W-1:0] cnt;

        assign kr  = gi_y + PAD_H - int'(oy_reg) * STRIDE_H;
        assign kc  = gi_x + PAD_W - int'(ox_reg) * STRIDE_W;
        assign hit = (kr >= 0) && (kr < KERNEL_H) && (kc >= 0) && (kc < KERNEL_W);
        assign c   = hit ? (gi_c * KERNEL_H * KERNEL_W + kr * KERNEL_W + kc) : 0;
        assign inc = hit && bus.in_p[CW_W'(c)];
        assign dec = hit && bus.in_m[CW_W'(c)];

        stoch_signed_acc_cell #(
          .CNT_W(CNT_W)
        ) u_cell (
          .CLK (CLK),
          .nRST(nRST),
          .en  (accept),
          .clr (clr),
          .inc (inc),
          .dec (dec),
          .cnt (cnt)
        );

        assign sum_w[gi_y][gi_x][gi_c] = cnt;
      end
    end
  end

  assign bus.in_ready  = in_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.out_sum   = sum_w;
endmodule

// File: tb/tb_stoch_signed_col2im.sv
// Randomised bench for stoch_signed_col2im against a per-beat scatter model.
module tb_stoch_signed_col2im;
  localparam int IH = 4, IW = 4, CH = 2, KH = 3, KW = 3, PH = 1, PW = 1, SH = 1, SW = 1;
  localparam int OW    = (IW + 2 * PW - KW) / SW + 1;
  localparam int OH    = (IH + 2 * PH - KH) / SH + 1;
  localparam int COL_H = OH * OW;
  localparam int COL_W = KH * KW * CH;
  localparam int CNT_W = 5;
  localparam int S_COL_W = 8;
  localparam int S_CNT_W = 2;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  stoch_signed_col2im_if #(.COL_WIDTH(COL_W), .IM_HEIGHT(IH), .IM_WIDTH(IW),
                           .CHANNELS(CH), .CNT_W(CNT_W)) bus ();
  stoch_signed_col2im_if #(.COL_WIDTH(S_COL_W), .IM_HEIGHT(4), .IM_WIDTH(4),
                           .CHANNELS(2), .CNT_W(S_CNT_W)) sbus ();

  stoch_signed_col2im dut (
    .CLK (CLK),
    .nRST(nRST),
    .bus (bus.slave)
  );

  stoch_signed_col2im #(
    .IM_HEIGHT(4), .IM_WIDTH(4), .CHANNELS(2), .KERNEL_H(2), .KERNEL_W(2),
    .PAD_H(0), .PAD_W(0), .STRIDE_H(2), .STRIDE_W(2)
  ) dut_stride (
    .CLK (CLK),
    .nRST(nRST),
    .bus (sbus.slave)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int dut_sum(input int y, input int x, input int c);
    logic signed [CNT_W-1:0] t;
    t = bus.out_sum[y][x][c];
    return int'(t);
  endfunction

  function automatic int s_sum(input int y, input int x, input int c);
    logic signed [S_CNT_W-1:0] t;
    t = sbus.out_sum[y][x][c];
    return int'(t);
  endfunction

  // Behavioural model: scatter every bit of each accepted patch with plain arithmetic
  int exp_acc[IH][IW][CH];
  int exp_row = 0;
  bit exp_busy = 1'b0;

  always @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      for (int y = 0; y < IH; y++)
        for (int x = 0; x < IW; x++)
          for (int c = 0; c < CH; c++) exp_acc[y][x][c] = 0;
      exp_row  = 0;
      exp_busy = 1'b0;
    end else if (exp_busy) begin
      if (bus.out_ready) begin
        for (int y = 0; y < IH; y++)
          for (int x = 0; x < IW; x++)
            for (int c = 0; c < CH; c++) exp_acc[y][x][c] = 0;
        exp_busy = 1'b0;
      end
    end else if (bus.in_valid) begin
      int oy, ox, ch, kr, kc, py, px;
      oy = exp_row / OW;
      ox = exp_row % OW;
      for (int b = 0; b < COL_W; b++) begin
        ch = b / (KH * KW);
        kr = (b / KW) % KH;
        kc = b % KW;
        py = oy * SH - PH + kr;
        px = ox * SW - PW + kc;
        if (py >= 0 && py < IH && px >= 0 && px < IW)
          exp_acc[py][px][ch] += int'(bus.in_p[b]) - int'(bus.in_m[b]);
      end
      exp_row++;
      if (exp_row == COL_H) begin
        exp_row  = 0;
        exp_busy = 1'b1;
      end
    end
  end

  // Every-cycle compare of the default instance against the model
  always @(negedge CLK) begin
    chk("in_ready", int'(bus.in_ready), int'(!exp_busy));
    chk("out_valid", int'(bus.out_valid), int'(exp_busy));
    if (exp_busy) begin
      for (int y = 0; y < IH; y++)
        for (int x = 0; x < IW; x++)
          for (int c = 0; c < CH; c++)
            if (dut_sum(y, x, c) != exp_acc[y][x][c])
              chk($sformatf("out_sum[%0d][%0d][%0d]", y, x, c), dut_sum(y, x, c), exp_acc[y][x][c]);
            else
              checks++;
    end
  end

  task automatic pin(input string name, input int y, input int x, input int c, input int v);
    chk({name, "_dut"}, dut_sum(y, x, c), v);
    chk({name, "_model"}, exp_acc[y][x][c], v);
  endtask

  // Tasks start and finish just after a falling edge
  task automatic send_beat(input logic [COL_W-1:0] p, input logic [COL_W-1:0] m);
    int n;
    repeat ($urandom_range(0, 2)) begin
      bus.in_valid = 1'b0;
      bus.in_p = COL_W'($urandom);
      bus.in_m = COL_W'($urandom);
      @(negedge CLK);
    end
    bus.in_valid = 1'b1;
    bus.in_p = p;
    bus.in_m = m;
    n = 0;
    while (!bus.in_ready && n < 64) begin
      @(negedge CLK);
      n++;
    end
    chk("in_ready_wait", int'(bus.in_ready), 1);
    @(negedge CLK);
    bus.in_valid = 1'b0;
  endtask

  task automatic run_frame(input int mode);
    logic [COL_W-1:0] p, m, kr0;
    int n;
    kr0 = '0;
    for (int b = 0; b < COL_W; b++)
      if (((b / KW) % KH) == 0) kr0[b] = 1'b1;
    for (int r = 0; r < COL_H; r++) begin
      case (mode)
        0: begin p = '1; m = '0; end
        1: begin p = '0; m = '1; end
        2: begin p = '1; m = '1; end
        3: begin p = (r == 0) ? kr0 : '0; m = '0; end
        default: begin p = COL_W'($urandom); m = COL_W'($urandom); end
      endcase
      send_beat(p, m);
    end
    n = 0;
    while (!bus.out_valid && n < 64) begin
      @(negedge CLK);
      n++;
    end
    chk("out_valid_wait", int'(bus.out_valid), 1);
    $display("frame mode %0d: %0d beats accepted", mode, COL_H);
  endtask

  task automatic drain(input int hold);
    bus.out_ready = 1'b0;
    repeat (hold) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.in_p = COL_W'($urandom);
      bus.in_m = COL_W'($urandom);
      @(negedge CLK);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge CLK);
    bus.out_ready = 1'b0;
    chk("in_ready_after_drain", int'(bus.in_ready), 1);
    $display("frame drained after %0d hold cycles", hold);
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_p = '0; bus.in_m = '0; bus.out_ready = 1'b0;
    sbus.in_valid = 1'b0; sbus.in_p = '0; sbus.in_m = '0; sbus.out_ready = 1'b0;
    repeat (3) @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
    chk("reset_in_ready", int'(bus.in_ready), 1);
    chk("reset_out_valid", int'(bus.out_valid), 0);
    chk("reset_s_in_ready", int'(sbus.in_ready), 1);
    chk("reset_s_out_valid", int'(sbus.out_valid), 0);

    run_frame(0);
    for (int c = 0; c < CH; c++) begin
      pin("pos_00", 0, 0, c, 4);
      pin("pos_01", 0, 1, c, 6);
      pin("pos_11", 1, 1, c, 9);
    end
    drain(5);

    run_frame(1);
    pin("neg_00", 0, 0, 0, -4);
    pin("neg_11", 1, 1, 1, -9);
    drain(2);

    run_frame(2);
    pin("both_11", 1, 1, 0, 0);
    drain(1);

    run_frame(3);
    pin("pad_00", 0, 0, 0, 0);
    pin("pad_01", 0, 1, 1, 0);
    drain(0);

    repeat (4) begin
      run_frame(4);
      drain($urandom_range(0, 5));
    end

    // Reset with a partial frame in flight
    for (int r = 0; r < 7; r++) send_beat('1, '0);
    #2 nRST = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
    chk("midreset_in_ready", int'(bus.in_ready), 1);
    chk("midreset_out_valid", int'(bus.out_valid), 0);
    $display("reset applied after 7 beats");
    run_frame(0);
    pin("fresh_11", 1, 1, 0, 9);
    pin("fresh_00", 0, 0, 1, 4);

    // Reset while a frame is being presented
    #2 nRST = 1'b0;
    #1 chk("drain_reset_out_valid", int'(bus.out_valid), 0);
    @(negedge CLK);
    #2 nRST = 1'b1;
    @(negedge CLK);
    $display("reset applied during drain");

    // Non-overlapping stride-2 instance
    sbus.in_p = '1;
    sbus.in_m = '0;
    for (int r = 0; r < 4; r++) begin
      chk("s_in_ready_beat", int'(sbus.in_ready), 1);
      sbus.in_valid = 1'b1;
      @(negedge CLK);
    end
    sbus.in_valid = 1'b0;
    chk("s_out_valid", int'(sbus.out_valid), 1);
    chk("s_in_ready_drain", int'(sbus.in_ready), 0);
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 4; x++)
        for (int c = 0; c < 2; c++)
          chk($sformatf("s_out_sum[%0d][%0d][%0d]", y, x, c), s_sum(y, x, c), 1);
    sbus.out_ready = 1'b1;
    @(negedge CLK);
    sbus.out_ready = 1'b0;
    chk("s_in_ready_after", int'(sbus.in_ready), 1);
    chk("s_out_valid_after", int'(sbus.out_valid), 0);
    $display("stride frame: 4 beats accepted and drained");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
